// File: rtl/probe_gen_pkg.sv
// Shared types and pure helpers for the probe pattern generator.
//   mode_t    : pattern mode selector (values 5..7 behave as hold)
//   state_t   : run-control FSM states
//   gray_of   : binary-to-Gray conversion
//   lfsr_next : one Fibonacci LFSR step for a pattern of 'width' bits
// Helpers work on a PAT_MAX_W-bit container so any pattern width up to that
// size can use them; callers zero-extend in and slice the result back out.
package probe_gen_pkg;

  localparam int PAT_MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_UP   = 3'd0,
    MODE_DOWN = 3'd1,
    MODE_WALK = 3'd2,
    MODE_LFSR = 3'd3,
    MODE_GRAY = 3'd4,
    MODE_HOLD = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [PAT_MAX_W-1:0] gray_of(input logic [PAT_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Shift left, feed the parity of the tapped bits into the LSB, then drop
  // anything above the pattern width.
  function automatic logic [PAT_MAX_W-1:0] lfsr_next(input logic [PAT_MAX_W-1:0] p,
                                                     input logic [PAT_MAX_W-1:0] taps,
                                                     input int unsigned          width);
    logic [PAT_MAX_W-1:0] mask;
    logic                 fb;
    mask = (width >= PAT_MAX_W) ? '1 : ((PAT_MAX_W'(1) << width) - PAT_MAX_W'(1));
    fb   = ^(p & taps);
    return ((p << 1) | {{(PAT_MAX_W-1){1'b0}}, fb}) & mask;
  endfunction

endpackage

// File: rtl/probe_pattern_gen_prescaler.sv
// Rate prescaler for the probe pattern generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return of the count to zero
//   enable     : count this cycle
//   div        : tick period is div+1 enabled cycles
//   tick       : single-cycle pulse on the last cycle of each period
module probe_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/probe_pattern_gen.sv
// Deterministic pattern source for logic-analyzer probe nets.
//   clk, rst_n : clock, asynchronous active-low reset
//   start/stop : run handshake; start acted on in IDLE only, stop beats start
//   mode       : 0 up, 1 down, 2 walking one, 3 LFSR, 4 Gray, 5..7 hold
//   div        : pattern advances every div+1 clocks
//   length     : advances per run, 0 = free-run
//   seed       : initial pattern value
//   pattern    : registered pattern output
//   step/wrap  : strobes in the cycle after an advance / sequence wrap
//   busy/done  : running flag / one-cycle burst-complete strobe
// All run controls are captured at start, so input changes mid-run are inert.
module probe_pattern_gen
  import probe_gen_pkg::*;
#(
  parameter int               WIDTH     = 7,
  parameter int               DIV_W     = 16,
  parameter int               LEN_W     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 7'b1100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] length,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] pattern,
  output logic             step,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  mode_t            mode_in, mode_l;
  logic [DIV_W-1:0] div_l;
  logic [LEN_W-1:0] len_l, adv_cnt, adv_cnt_inc;
  logic [WIDTH-1:0] seed_l, seed_adj, load_pat;
  logic [WIDTH-1:0] bin, bin_inc, bin_nxt, pat_nxt;
  logic             wrap_nxt, load, adv, tick, pre_en, pre_clear;
  logic [PAT_MAX_W-1:0] lfsr_w, gray_w, seed_gray_w;
  logic             unused_hi_bits;

  probe_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (pre_clear),
    .enable (pre_en),
    .div    (div_l),
    .tick   (tick)
  );

  // Load value: walking one and LFSR cannot run from an all-zero seed, and
  // Gray mode counts internally in binary and shows the Gray code.
  always_comb begin
    mode_in     = mode_t'(mode);
    seed_adj    = seed;
    if ((mode_in == MODE_WALK || mode_in == MODE_LFSR) && seed == '0)
      seed_adj = WIDTH'(1);
    seed_gray_w = gray_of(PAT_MAX_W'(seed));
    load_pat    = (mode_in == MODE_GRAY) ? seed_gray_w[WIDTH-1:0] : seed_adj;
  end

  // Next pattern and wrap detection for the latched mode.
  always_comb begin
    pat_nxt  = pattern;
    bin_nxt  = bin;
    wrap_nxt = 1'b0;
    bin_inc  = bin + WIDTH'(1);
    lfsr_w   = lfsr_next(PAT_MAX_W'(pattern), PAT_MAX_W'(LFSR_TAPS), WIDTH);
    gray_w   = gray_of(PAT_MAX_W'(bin_inc));
    case (mode_l)
      MODE_UP: begin
        pat_nxt  = pattern + WIDTH'(1);
        wrap_nxt = &pattern;
      end
      MODE_DOWN: begin
        pat_nxt  = pattern - WIDTH'(1);
        wrap_nxt = (pattern == '0);
      end
      MODE_WALK: begin
        pat_nxt  = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
        wrap_nxt = pattern[WIDTH-1];
      end
      MODE_LFSR: begin
        pat_nxt  = lfsr_w[WIDTH-1:0];
        wrap_nxt = (lfsr_w[WIDTH-1:0] == seed_l);
      end
      MODE_GRAY: begin
        bin_nxt  = bin_inc;
        pat_nxt  = gray_w[WIDTH-1:0];
        wrap_nxt = &bin;
      end
      default: ;
    endcase
  end

  assign unused_hi_bits = ^{lfsr_w[PAT_MAX_W-1:WIDTH], gray_w[PAT_MAX_W-1:WIDTH],
                            seed_gray_w[PAT_MAX_W-1:WIDTH]};

  assign adv_cnt_inc = adv_cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Run control. stop takes priority over both start and a same-cycle advance.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    adv       = 1'b0;
    pre_en    = 1'b0;
    pre_clear = 1'b1;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        pre_en    = 1'b1;
        pre_clear = 1'b0;
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          adv = 1'b1;
          if (len_l != '0 && adv_cnt_inc == len_l) state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      bin     <= '0;
      seed_l  <= '0;
      mode_l  <= MODE_UP;
      div_l   <= '0;
      len_l   <= '0;
      adv_cnt <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      step <= adv;
      wrap <= adv & wrap_nxt;
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
      if (load) begin
        mode_l  <= mode_in;
        div_l   <= div;
        len_l   <= length;
        seed_l  <= seed_adj;
        bin     <= seed;
        pattern <= load_pat;
        adv_cnt <= '0;
      end else if (adv) begin
        pattern <= pat_nxt;
        bin     <= bin_nxt;
        if (len_l != '0) adv_cnt <= adv_cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_probe_pattern_gen.sv
module tb_probe_pattern_gen;

  localparam int W    = 7;
  localparam int TAPS = 'b1100000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [2:0]   mode = '0;
  logic [15:0]  div = '0;
  logic [15:0]  length = '0;
  logic [W-1:0] seed = '0;
  logic [W-1:0] pattern;
  logic         step, wrap, busy, done;

  probe_pattern_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .mode    (mode),
    .div     (div),
    .length  (length),
    .seed    (seed),
    .pattern (pattern),
    .step    (step),
    .wrap    (wrap),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] pat;
    logic         wrap;
  } exp_t;

  exp_t sb_q[$];
  int   done_q[$];
  bit   seen[128];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: patterns as plain integers modulo 128.
  function automatic int adj_seed(input int m, input int s);
    if ((m == 2 || m == 3) && s == 0) return 1;
    return s;
  endfunction

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_adv(input int m, input int sd, inout int p, inout int b, output bit w);
    w = 1'b0;
    case (m)
      0: begin w = (p == 127); p = (p + 1) % 128; end
      1: begin w = (p == 0); p = (p + 127) % 128; end
      2: begin w = (p >= 64); p = (p * 2) % 128 + p / 64; end
      3: begin p = (p * 2) % 128 + ($countones(p & TAPS) % 2); w = (p == sd); end
      4: begin w = (b == 127); b = (b + 1) % 128; p = gray(b); end
      default: ;
    endcase
  endtask

  // Start a run and queue every expected step (and the done strobe).
  task automatic launch(input int m, input int d, input int len, input int sd, input int nstep,
                        output int n0, output int p);
    int   b;
    bit   w;
    exp_t e;
    mode   = 3'(m);
    div    = 16'(d);
    length = 16'(len);
    seed   = W'(sd);
    start  = 1'b1;
    stop   = 1'b0;
    @(posedge clk); #1;
    n0    = cyc;
    start = 1'b0;
    b = sd;
    p = (m == 4) ? gray(sd) : adj_seed(m, sd);
    check("load_busy", busy, 1);
    check("load_pattern", pattern, p);
    for (int k = 1; k <= ((len != 0) ? len : nstep); k++) begin
      model_adv(m, adj_seed(m, sd), p, b, w);
      e.cyc  = n0 + (d + 1) * k;
      e.pat  = W'(p);
      e.wrap = w;
      sb_q.push_back(e);
    end
    if (len != 0) done_q.push_back(n0 + (d + 1) * len);
  endtask

  // Burst (len!=0) runs to completion; free-run (len==0) is stopped on the
  // edge that would have produced advance nstep+1.
  task automatic run(input int m, input int d, input int len, input int sd, input int nstep,
                     input bit poke, input bit dpoke);
    int n0, p, end_edge;
    launch(m, d, len, sd, nstep, n0, p);
    end_edge = (len != 0) ? n0 + (d + 1) * len : n0 + (d + 1) * (nstep + 1);
    while (cyc < end_edge) begin
      check("busy_run", busy, 1);
      mode   = 3'($urandom);
      div    = 16'($urandom);
      length = 16'($urandom);
      seed   = W'($urandom);
      start  = poke && (cyc == n0 + 1);
      stop   = (len == 0) && (cyc == end_edge - 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    check("end_busy", busy, 0);
    check("end_pattern", pattern, p);
    if (len != 0) begin
      check("end_done", done, 1);
      start = dpoke;
      @(posedge clk); #1;
      start = 1'b0;
      check("after_done_busy", busy, 0);
      check("after_done_done", done, 0);
    end else begin
      check("stop_no_step", step, 0);
    end
  endtask

  // Monitor: every step/done the DUT presents is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (step) begin
        seen[pattern] = 1'b1;
        if (sb_q.size() == 0) begin
          check("step_unexpected", step, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("step_cycle", cyc, e.cyc);
          check("step_pattern", pattern, e.pat);
          check("step_wrap", wrap, e.wrap);
        end
      end else if (wrap) begin
        check("wrap_without_step", wrap, 0);
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", done, 0);
        else                    check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    int n0, p, cnt;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pattern", pattern, 0);
    check("rst_step", step, 0);
    check("rst_wrap", wrap, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Up count across the all-ones boundary.
    run(0, 0, 0, 'h7E, 3, 1'b0, 1'b0);

    // Full LFSR period from seed 1.
    foreach (seen[i]) seen[i] = 1'b0;
    run(3, 0, 0, 1, 127, 1'b0, 1'b0);
    cnt = 0;
    foreach (seen[i]) if (seen[i]) cnt++;
    check("lfsr_distinct", cnt, 127);
    check("lfsr_no_zero", seen[0], 0);

    // Walking one burst with prescale, start held into the DONE cycle.
    run(2, 2, 5, 0, 0, 1'b0, 1'b1);

    // Gray burst with a start pulse mid-run.
    run(4, 0, 4, 0, 0, 1'b1, 1'b0);

    // Down free-run stopped on an advance, then start+stop together.
    run(1, 1, 0, 0, 4, 1'b0, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_pattern", pattern, 'h7C);
    @(posedge clk); #1;
    check("start_stop_busy2", busy, 0);

    // Reset in the middle of a long burst.
    launch(0, 0, 100, int'($urandom_range(0, 127)), 0, n0, p);
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_pattern", pattern, 0);
    check("midrst_step", step, 0);
    check("midrst_wrap", wrap, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    sb_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 0, 100, int'($urandom_range(0, 127)), 0, 1'b0, 1'b0);

    // Randomized runs across all modes.
    for (int r = 0; r < 24; r++) begin
      int m, d, sd;
      bit burst;
      m     = int'($urandom_range(0, 7));
      d     = int'($urandom_range(0, 3));
      sd    = int'($urandom_range(0, 127));
      burst = 1'($urandom);
      if (burst) run(m, d, int'($urandom_range(1, 12)), sd, 0, 1'($urandom), 1'($urandom));
      else       run(m, d, 0, sd, int'($urandom_range(1, 10)), 1'($urandom), 1'b0);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/probe_pattern_gen.md
Name: probe_pattern_gen

Overview:
Parametrised stimulus generator that drives logic-analyzer probe nets with selectable, deterministic patterns.
- Replaces the free-running fixed-width counter in example top levels.
- Adds selectable modes, a rate prescaler, seeded start, burst length, a start/stop handshake, and step/wrap strobes.
- Output `pattern` is split by the instantiating top level into individual probes for the manta core, so captures can be checked against a known sequence.

Parameters:
- WIDTH, 7: total pattern width in bits (min 2).
- DIV_W, 16: width of the prescaler divide input.
- LEN_W, 16: width of the burst-length input.
- LFSR_TAPS, 7'b1100000: Fibonacci feedback mask, WIDTH bits. Default is x^7+x^6+1, maximal length, period 127.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run (level sampled per clock; acted on only in IDLE).
- stop  in  1  abort a run.
- mode  in  3  0=count up, 1=count down, 2=walking one, 3=LFSR, 4=gray count, 5-7=hold.
- div  in  DIV_W  pattern advances every div+1 clocks.
- length  in  LEN_W  number of advances per run; 0 = free-run.
- seed  in  WIDTH  initial pattern value.
- pattern  out  WIDTH  generated pattern, registered.
- step  out  1  1-cycle strobe, high the cycle after `pattern` updates by an advance.
- wrap  out  1  1-cycle strobe coincident with step when the sequence wraps.
- busy  out  1  high while in RUN.
- done  out  1  1-cycle strobe on burst completion.

Behaviour:
- Reset (async assert, sync release):
  - pattern=0, step=0, wrap=0, busy=0, done=0.
  - State IDLE; prescaler and advance counters cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1 and stop=0 at edge N: latch mode, div, length and seed.
  - Load pattern from seed, with per-mode adjustments: walking one with seed=0 loads 1; LFSR with seed=0 loads 1; gray loads internal binary b=seed and drives pattern=b^(b>>1).
  - busy=1 from edge N; go to RUN.
  - start with stop=1 in the same cycle: stop wins, stay IDLE.
  - In IDLE, pattern holds its last value.
- RUN:
  - Prescaler counts 0..div_latched. Advances occur at edges N+(div+1)k, k>=1.
  - div=0 gives an advance every clock.
  - On each advance, pattern <= next(pattern) and step=1 for the following cycle.
- next() by mode:
  - Up: +1 modulo 2^WIDTH. wrap when all-ones -> 0.
  - Down: -1 modulo 2^WIDTH. wrap when 0 -> all-ones.
  - Walking one: rotate left. wrap when the set bit moves MSB -> bit0.
  - LFSR: shift left, new LSB = ^(pattern & LFSR_TAPS). wrap when the next value equals the latched (adjusted) seed.
  - Gray: b+1, pattern = gray(b). wrap when b goes all-ones -> 0.
  - Hold: pattern unchanged. step still pulses; wrap never asserts.
- Burst:
  - When length!=0, the advance counter increments per advance.
  - On the advance that makes it equal to length, the same edge moves to DONE. busy=0 from that edge; pattern holds the final value.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- stop in RUN:
  - Next edge -> IDLE, busy=0, no done strobe.
  - If an advance coincides, stop wins and pattern does not advance.
- start while busy: ignored. Input changes mid-run have no effect, because all controls are latched at start.
- Reset mid-run: immediate return to reset values; no done.
- Arithmetic is unsigned and wraps at WIDTH bits. The advance counter is LEN_W bits and compares for equality only.

Decomposition:
- Package probe_gen_pkg holds:
  - mode_t enum (3 bits; MODE_UP, MODE_DOWN, MODE_WALK, MODE_LFSR, MODE_GRAY, MODE_HOLD).
  - state_t enum (S_IDLE, S_RUN, S_DONE).
  - Pure functions gray_of() and lfsr_next(), parametrised via arguments.
- Sub-module probe_prescaler (DIV_W):
  - Inputs: clk, rst_n, clear, enable, div.
  - Output: tick, 1-cycle, every div+1 enabled cycles.
- The top FSM, pattern register and strobe logic live in probe_pattern_gen.

Test Plan:
- Reset, then start with mode=0, div=0, length=0, seed=7'h7E -> pattern 7E,7F,00,01 on consecutive cycles; step every cycle; wrap with the 7F->00 advance only; busy stays 1.
- mode=3, seed=1, div=0, length=0 -> after 127 advances pattern returns to 1 with wrap=1; no wrap before; all 127 nonzero values seen exactly once.
- mode=2, seed=0, div=2, length=5 -> pattern 01,02,04,08,10,20 with advances every 3 clocks; done pulses once after the 5th advance; busy drops on that edge; pattern holds 20.
- mode=4, seed=0, div=0, length=4 -> pattern 00,01,03,02,06; done after the 4th advance; start pulsed while busy has no effect.
- Free-run mode=1, seed=0: assert stop on an advance cycle -> pattern does not advance, busy=0 next cycle, done never asserts. Then start with stop=1 together -> stays IDLE.
- Drop rst_n mid-burst (mode=0, length=100) -> all outputs 0 asynchronously; after release, a fresh start runs the full 100 advances.
